// File: rtl/segasys1_enc_pkg.sv
// Shared definitions for the Sega System 1 program encryptor:
// mode encodings, FSM states, swap table and the Type 1 / Type 2 helpers.
package segasys1_enc_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_T1   = 2'd1;
    localparam logic [1:0] MODE_T2   = 2'd2;

    localparam logic [7:0] SWAP_COUNT = 8'd24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_T2_RD   = 3'd1,
        ST_T2_CALC = 3'd2,
        ST_T1_SCAN = 3'd3,
        ST_DONE    = 3'd4
    } enc_state_e;

    // XOR mask the decryptor applies to the table byte when bit 7 of the
    // encrypted byte is set.
    function automatic logic [7:0] t1_xorv(input logic f);
        return {f, 1'b0, f, 1'b0, f, 3'b000};
    endfunction

    // Destination bit positions {A,B,C,D} for y[6], y[4], y[2], y[0].
    function automatic logic [11:0] swap_quad(input logic [4:0] sel);
        logic [11:0] q;
        case (sel)
            5'd0:    q = {3'd6, 3'd4, 3'd2, 3'd0};
            5'd1:    q = {3'd4, 3'd6, 3'd2, 3'd0};
            5'd2:    q = {3'd2, 3'd4, 3'd6, 3'd0};
            5'd3:    q = {3'd0, 3'd4, 3'd2, 3'd6};
            5'd4:    q = {3'd6, 3'd2, 3'd4, 3'd0};
            5'd5:    q = {3'd6, 3'd0, 3'd2, 3'd4};
            5'd6:    q = {3'd6, 3'd4, 3'd0, 3'd2};
            5'd7:    q = {3'd2, 3'd6, 3'd4, 3'd0};
            5'd8:    q = {3'd4, 3'd2, 3'd6, 3'd0};
            5'd9:    q = {3'd4, 3'd6, 3'd0, 3'd2};
            5'd10:   q = {3'd6, 3'd0, 3'd4, 3'd2};
            5'd11:   q = {3'd0, 3'd6, 3'd4, 3'd2};
            5'd12:   q = {3'd4, 3'd0, 3'd6, 3'd2};
            5'd13:   q = {3'd0, 3'd4, 3'd6, 3'd2};
            5'd14:   q = {3'd6, 3'd2, 3'd0, 3'd4};
            5'd15:   q = {3'd2, 3'd6, 3'd0, 3'd4};
            5'd16:   q = {3'd0, 3'd6, 3'd2, 3'd4};
            5'd17:   q = {3'd2, 3'd0, 3'd6, 3'd4};
            5'd18:   q = {3'd0, 3'd2, 3'd6, 3'd4};
            5'd19:   q = {3'd4, 3'd2, 3'd0, 3'd6};
            5'd20:   q = {3'd2, 3'd4, 3'd0, 3'd6};
            5'd21:   q = {3'd4, 3'd0, 3'd2, 3'd6};
            5'd22:   q = {3'd2, 3'd0, 3'd4, 3'd6};
            5'd23:   q = {3'd0, 3'd2, 3'd4, 3'd6};
            default: q = {3'd6, 3'd4, 3'd2, 3'd0};
        endcase
        return q;
    endfunction

    // Type 2 table index from the 16-bit address {m1, ad}.
    function automatic logic [6:0] t2_index(input logic [15:0] a);
        logic unused_bits;
        unused_bits = ^{a[13], a[11:10], a[8:7], a[5:4], a[2:1]};
        return {a[14], a[12], a[9], a[6], a[3], a[0], ~a[15]};
    endfunction

    // Type 2 forward transform: XOR, then move the even bits to the
    // positions that the decryptor's swap will pull them back from.
    function automatic logic [7:0] t2_encrypt(input logic [7:0] pt,
                                              input logic [7:0] xd,
                                              input logic [4:0] sd);
        logic [7:0]  y;
        logic [7:0]  c;
        logic [11:0] q;
        y = pt ^ xd;
        q = swap_quad(sd);
        c = y & 8'hAA;
        c[q[11:9]] = y[6];
        c[q[8:6]]  = y[4];
        c[q[5:3]]  = y[2];
        c[q[2:0]]  = y[0];
        return c;
    endfunction

    // Type 1 candidate k: unencrypted bits of pt, bits 7/5/3 taken from k.
    function automatic logic [7:0] t1_cand(input logic [7:0] pt, input logic [2:0] k);
        return (pt & 8'h57) | {k[2], 1'b0, k[1], 1'b0, k[0], 3'b000};
    endfunction

    // Type 1 table index for a candidate byte c at address a.
    function automatic logic [6:0] t1_index(input logic [15:0] a, input logic [7:0] c);
        logic f;
        logic unused_bits;
        unused_bits = ^{a[14:13], a[11:9], a[7:5], a[3:1], c[6], c[4], c[2:0]};
        f = c[7];
        return {a[12], a[8], a[4], a[0], ~a[15], c[5] ^ f, c[3] ^ f};
    endfunction

    // What the on-board decryptor produces for byte c given table data td.
    function automatic logic [7:0] t1_decrypt(input logic [7:0] c, input logic [7:0] td);
        return (c & 8'h57) | (td ^ t1_xorv(c[7]));
    endfunction

endpackage

// File: rtl/segasys1_enc_tbl.sv
// 128x8 key table: written from the ROM download bus when the address
// falls in this table's 128-byte window, read synchronously by the engine.
module segasys1_enc_tbl #(
    parameter logic [24:0] BASE = 25'h60400
) (
    input  logic        clk,
    input  logic [18:0] rom_ad,
    input  logic [7:0]  rom_dt,
    input  logic        rom_en,
    input  logic [6:0]  rd_addr,
    output logic [7:0]  rd_data
);

    logic [7:0] mem_q [128];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;
    logic       wr_en;

    assign wr_en = rom_en && (rom_ad[18:7] == BASE[18:7]);

    // Download write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[rom_ad[6:0]] <= rom_dt;
        end
    end

    // Read data for the address presented this cycle.
    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    // Registered read: data appears the cycle after the address.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/segasys1_prgenc.sv
// Sega System 1 program encryptor: turns a plaintext byte at a CPU address
// into the byte the on-board decryptor maps back to it.
//
// state      | meaning
// IDLE       | waiting for a request
// T2_RD      | Type 2 index presented to T and S
// T2_CALC    | Type 2 table data back, build ciphertext
// T1_SCAN    | Type 1 candidate search, one table read per cycle
// DONE       | result held until out_ready
module segasys1_prgenc
    import segasys1_enc_pkg::*;
#(
    parameter logic [24:0] T1_BASE     = 25'h60400,
    parameter logic [24:0] T2_SWP_BASE = 25'h60480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_m1,
    input  logic [14:0] in_ad,
    input  logic [7:0]  in_pt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_ct,
    output logic        out_err,
    input  logic [24:0] ROMAD,
    input  logic [7:0]  ROMDT,
    input  logic        ROMEN
);

    enc_state_e state_q, state_d;

    logic [15:0] a_q, a_d;
    logic [7:0]  pt_q, pt_d;
    logic [3:0]  issue_k_q, issue_k_d;
    logic        cmp_vld_q, cmp_vld_d;
    logic [2:0]  cmp_k_q, cmp_k_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_ct_q, out_ct_d;
    logic        out_err_q, out_err_d;

    logic [6:0]  t_rd_addr;
    logic [6:0]  s_rd_addr;
    logic [7:0]  t_rd_data;
    logic [7:0]  s_rd_data;

    logic        accept;
    logic        is_pass;
    logic [7:0]  cmp_cand;
    logic        t1_match;
    logic        t1_last;
    logic        unused_romad_hi;

    assign unused_romad_hi = ^ROMAD[24:19];

    segasys1_enc_tbl #(.BASE(T1_BASE)) u_tbl_t (
        .clk     (clk),
        .rom_ad  (ROMAD[18:0]),
        .rom_dt  (ROMDT),
        .rom_en  (ROMEN),
        .rd_addr (t_rd_addr),
        .rd_data (t_rd_data)
    );

    segasys1_enc_tbl #(.BASE(T2_SWP_BASE)) u_tbl_s (
        .clk     (clk),
        .rom_ad  (ROMAD[18:0]),
        .rom_dt  (ROMDT),
        .rom_en  (ROMEN),
        .rd_addr (s_rd_addr),
        .rd_data (s_rd_data)
    );

    // Downloads take priority over new requests so a request never races a table write.
    assign in_ready = (state_q == ST_IDLE) && !out_valid_q && !ROMEN && !reset;
    assign accept   = in_valid && in_ready;
    assign is_pass  = (mode != MODE_T1) && (mode != MODE_T2);

    // Type 1 compare for the candidate whose table read returned this cycle.
    assign cmp_cand = t1_cand(pt_q, cmp_k_q);
    assign t1_match = cmp_vld_q && (t1_decrypt(cmp_cand, t_rd_data) == pt_q);
    assign t1_last  = cmp_vld_q && (cmp_k_q == 3'd7);

    // Table read addresses: T is shared by the Type 2 lookup and the Type 1 scan.
    always_comb begin
        s_rd_addr = t2_index(a_q);
        t_rd_addr = t1_index(a_q, t1_cand(pt_q, issue_k_q[2:0]));
        if (state_q == ST_T2_RD) begin
            t_rd_addr = t2_index(a_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mode == MODE_T1) begin
                        state_d = ST_T1_SCAN;
                    end else if (mode == MODE_T2) begin
                        state_d = ST_T2_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_T2_RD:   state_d = ST_T2_CALC;
            ST_T2_CALC: state_d = ST_DONE;
            ST_T1_SCAN: begin
                if (t1_match || t1_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        a_d         = a_q;
        pt_d        = pt_q;
        issue_k_d   = issue_k_q;
        cmp_vld_d   = 1'b0;
        cmp_k_d     = cmp_k_q;
        out_valid_d = out_valid_q;
        out_ct_d    = out_ct_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d       = {in_m1, in_ad};
                    pt_d      = in_pt;
                    issue_k_d = 4'd0;
                    if (is_pass) begin
                        out_valid_d = 1'b1;
                        out_ct_d    = in_pt;
                        out_err_d   = 1'b0;
                    end
                end
            end
            ST_T2_CALC: begin
                out_valid_d = 1'b1;
                if (s_rd_data >= SWAP_COUNT) begin
                    out_ct_d  = pt_q;
                    out_err_d = 1'b1;
                end else begin
                    out_ct_d  = t2_encrypt(pt_q, t_rd_data, s_rd_data[4:0]);
                    out_err_d = 1'b0;
                end
            end
            ST_T1_SCAN: begin
                if (!issue_k_q[3]) begin
                    cmp_vld_d = 1'b1;
                    cmp_k_d   = issue_k_q[2:0];
                    issue_k_d = issue_k_q + 4'd1;
                end
                // A match drops the read already in flight for the next k.
                if (t1_match) begin
                    cmp_vld_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_ct_d    = cmp_cand;
                    out_err_d   = 1'b0;
                end else if (t1_last) begin
                    cmp_vld_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_ct_d    = pt_q;
                    out_err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; operands and tables survive reset, outputs do not.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_ct_q    <= 8'h00;
            out_err_q   <= 1'b0;
        end else begin
            cmp_vld_q   <= cmp_vld_d;
            out_valid_q <= out_valid_d;
            out_ct_q    <= out_ct_d;
            out_err_q   <= out_err_d;
        end
        a_q       <= a_d;
        pt_q      <= pt_d;
        issue_k_q <= issue_k_d;
        cmp_k_q   <= cmp_k_d;
    end

    assign out_valid = out_valid_q;
    assign out_ct    = out_ct_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_segasys1_prgenc.sv
// Directed bench for segasys1_prgenc with a scoreboard queue and a monitor.
module tb_segasys1_prgenc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_m1 = 1'b0;
    logic [14:0] in_ad = 15'd0;
    logic [7:0]  in_pt = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_ct;
    logic        out_err;
    logic [24:0] ROMAD = 25'd0;
    logic [7:0]  ROMDT = 8'd0;
    logic        ROMEN = 1'b0;

    always #5 clk = ~clk;

    segasys1_prgenc dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m1     (in_m1),
        .in_ad     (in_ad),
        .in_pt     (in_pt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .out_err   (out_err),
        .ROMAD     (ROMAD),
        .ROMDT     (ROMDT),
        .ROMEN     (ROMEN)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ct;
        logic       err;
        int         at;
        int         id;
    } exp_t;

    exp_t sb_q[$];
    logic prev_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every new result is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && !prev_v) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%0h required=none", out_ct);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("ct_%0d", e.id), {24'd0, out_ct}, {24'd0, e.ct});
                chk($sformatf("err_%0d", e.id), {31'd0, out_err}, {31'd0, e.err});
                chk($sformatf("latency_%0d", e.id), cyc, e.at);
            end
        end
        prev_v = (out_valid === 1'b1);
    end

    task automatic tbl_wr(input logic [24:0] ad, input logic [7:0] d);
        @(negedge clk);
        ROMAD = ad;
        ROMDT = d;
        ROMEN = 1'b1;
        @(negedge clk);
        ROMEN = 1'b0;
    endtask

    // Returns at the negedge inside E0+1.
    task automatic send(input int id, input logic [1:0] md, input logic m1,
                        input logic [14:0] ad, input logic [7:0] pt,
                        input logic [7:0] ect, input logic eerr, input int lat);
        int n;
        bit ok;
        exp_t e;
        n  = 0;
        ok = 0;
        @(negedge clk);
        mode     = md;
        in_m1    = m1;
        in_ad    = ad;
        in_pt    = pt;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            #4;
            if (in_ready === 1'b1) begin
                e.ct  = ect;
                e.err = eerr;
                e.at  = cyc + lat;
                e.id  = id;
                sb_q.push_back(e);
                ok = 1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        // Disturb inputs after acceptance; the result must not change.
        mode  = 2'd1;
        in_m1 = ~m1;
        in_ad = ~ad;
        in_pt = ~pt;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout_%0d actual=no_accept required=accept", id);
        end
    endtask

    task automatic wait_done(input int id);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL done_timeout_%0d actual=pending required=complete", id);
            sb_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ct", {24'd0, out_ct}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 128; i++) begin
            tbl_wr(25'h60400 + 25'(i), 8'h00);
            tbl_wr(25'h60480 + 25'(i), 8'h00);
        end

        // Type 1 with an all-zero T table, address {m1=1, ad=0}.
        send(1, 2'd1, 1'b1, 15'd0, 8'h00, 8'h00, 1'b0, 3);
        wait_done(1);
        send(2, 2'd1, 1'b1, 15'd0, 8'hA8, 8'h80, 1'b0, 7);
        wait_done(2);
        send(3, 2'd1, 1'b1, 15'd0, 8'h28, 8'h28, 1'b1, 10);
        wait_done(3);

        // Reset in E0+4 of a scan aborts it.
        send(4, 2'd1, 1'b1, 15'd0, 8'hA8, 8'h80, 1'b0, 7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.delete();
        send(5, 2'd1, 1'b1, 15'd0, 8'hA8, 8'h80, 1'b0, 7);
        wait_done(5);

        // Type 2.
        tbl_wr(25'h60480, 8'd1);
        send(6, 2'd2, 1'b1, 15'd0, 8'h40, 8'h10, 1'b0, 3);
        wait_done(6);
        tbl_wr(25'h60400, 8'h01);
        send(7, 2'd2, 1'b1, 15'd0, 8'h40, 8'h11, 1'b0, 3);
        wait_done(7);
        tbl_wr(25'h60480, 8'd3);
        send(8, 2'd2, 1'b1, 15'd0, 8'h00, 8'h40, 1'b0, 3);
        wait_done(8);
        tbl_wr(25'h60480, 8'd24);
        send(9, 2'd2, 1'b1, 15'd0, 8'h5A, 8'h5A, 1'b1, 3);
        wait_done(9);

        // Passthrough, with the result held while out_ready is low.
        out_ready = 1'b0;
        send(10, 2'd0, 1'b0, 15'h1234, 8'h3C, 8'h3C, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold_ct_%0d", i), {24'd0, out_ct}, 32'h3C);
            chk($sformatf("hold_err_%0d", i), {31'd0, out_err}, 32'd0);
            chk($sformatf("hold_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_done(10);
        send(11, 2'd3, 1'b1, 15'h7FFF, 8'hC3, 8'hC3, 1'b0, 1);
        wait_done(11);

        // Download strobe blocks requests; the write lands in T[5].
        @(negedge clk);
        ROMAD = 25'h60405;
        ROMDT = 8'h33;
        ROMEN = 1'b1;
        #1;
        chk("romen_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        ROMEN = 1'b0;
        #1;
        chk("post_romen_in_ready", {31'd0, in_ready}, 32'd1);
        // ix = 5 needs a3=1, a0=0, m1=0; S[5] is 0 (identity swap).
        send(12, 2'd2, 1'b0, 15'h0008, 8'h0F, 8'h3C, 1'b0, 3);
        wait_done(12);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/segasys1_prgenc.md
Name: segasys1_prgenc

Overview:
- Program ROM encryptor for Sega System 1 Type 1 and Type 2 opcode/data encryption; exact inverse of the on-board program decryptor.
- Accepts a plaintext byte with its 15-bit CPU address and M1 flag. Returns the ciphertext byte that the decryptor maps back to that plaintext.
- Used by the ROM build/self-test path and the verification bench. Key tables are loaded from the same download bus as the decryptor.

Parameters:
- T1_BASE, 25'h60400, download address of the Type 1 table / Type 2 XOR table (128 bytes).
- T2_SWP_BASE, 25'h60480, download address of the Type 2 swap-select table (128 bytes).

Ports:
- clk  in  1  system clock; also the download clock.
- reset  in  1  synchronous, active-high.
- mode  in  2  0 passthrough, 1 Type 1, 2 Type 2, 3 treated as 0; sampled at accept.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_m1  in  1  M1 (opcode fetch) flag; forms address bit 15.
- in_ad  in  15  CPU address.
- in_pt  in  8  plaintext byte.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_ct  out  8  ciphertext.
- out_err  out  1  no ciphertext exists; out_ct = plaintext.
- ROMAD  in  25  download address.
- ROMDT  in  8  download data.
- ROMEN  in  1  download write strobe.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FSM IDLE, out_valid 0, out_ct 0, out_err 0. Table contents are retained across reset.
- in_ready is high only when state is IDLE, out_valid is 0, ROMEN is 0 and reset is 0. There is one outstanding request at a time.
- The accept cycle is E0. The engine registers a = {in_m1, in_ad}, pt and mode at E0.
- Table writes:
  - ROMEN with ROMAD[18:7] equal to T1_BASE[18:7] writes table T, entry ROMAD[6:0].
  - ROMEN with ROMAD[18:7] equal to T2_SWP_BASE[18:7] writes table S.
  - Writes use a separate port and are always accepted.
  - A write during an in-flight operation gives an unspecified ciphertext. The bench does not check this case.
- Both tables are synchronous read: address registered in cycle n, data valid in cycle n+1.
- PASS (mode 0/3): out_ct = pt, out_err = 0, out_valid rises at E0+1.
- TYPE2 (states T2_RD, T2_CALC):
  - Index ix = {a14, a12, a9, a6, a3, a0, ~a15}, presented at E0+1. Data xd = T[ix] and sd = S[ix] are available at E0+2.
  - y = pt ^ xd.
  - sd selects the quadruple (A, B, C, D) from the 24-entry swap list in the package.
  - Ciphertext: c[A]=y[6], c[B]=y[4], c[C]=y[2], c[D]=y[0]; odd bits c[7,5,3,1] = y[7,5,3,1].
  - out_valid rises at E0+3.
  - sd >= 24: out_err = 1, out_ct = pt.
- TYPE1 (state T1_SCAN): candidate search for k = 0..7.
  - Candidate c_k = pt & 8'h57, with c[7]=k[2], c[5]=k[1], c[3]=k[0].
  - f = c[7]; idx = {a12, a8, a4, a0, ~a15, c[5]^f, c[3]^f}.
  - Decrypted value: dec = (c & 8'h57) | (T[idx] ^ {f,0,f,0,f,000}).
  - Address for k is issued at E0+1+k. Compare for k happens at E0+2+k, one issue per cycle, pipelined.
  - The first (lowest) k with dec == pt wins. Issuing stops at the match; the already-issued read is discarded. out_ct = c_k, out_valid rises at E0+3+k.
  - No match after k=7: out_err = 1, out_ct = pt, out_valid rises at E0+10.
- DONE: out_valid, out_ct and out_err hold stable while out_ready = 0. On out_ready, out_valid drops next cycle and the FSM returns to IDLE. in_ready may rise in that same cycle.
- Mid-operation: a mode or input change after E0 has no effect. reset at any point aborts the operation and forces reset values next cycle.

Decomposition:
- Package segasys1_enc_pkg:
  - mode encodings (MODE_PASS, MODE_T1, MODE_T2).
  - T1_XORV function of f.
  - 24-entry swap quadruple constant table.
  - Type 1 index and decrypt functions, shared with the bench reference model.
- Sub-module segasys1_enc_tbl: 128x8 table, download write port decoded by a base parameter, synchronous read port. Instantiated twice (T, S).

Test Plan:
- Mode 2, S[0]=1, T[0]=0x00, m1=1, ad=0, pt=0x40 -> ct=0x10, err=0, out_valid at E0+3. Then T[0]=0x01, pt=0x40 -> ct=0x11.
- Mode 2, S[0]=24, pt=0x5A -> err=1, ct=0x5A.
- Mode 1, T all 0x00, m1=1, ad=0:
  - pt=0x00 -> ct=0x00 at E0+3.
  - pt=0xA8 -> ct=0x80 at E0+7.
  - pt=0x28 -> err=1, ct=0x28 at E0+10.
- Mode 0, pt=0x3C -> ct=0x3C at E0+1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- ROMEN pulsed while idle -> in_ready=0 that cycle. Table write at ROMAD=0x60405 lands in T[5]. Verify via a Type 2 lookup at the address giving ix=5.
- Assert reset at E0+4 of a Type 1 scan -> next cycle out_valid=0, in_ready=1. Tables are retained, and a repeat request yields identical ciphertext.
